// File: rtl/instruction_fetch_queue_if.sv
// Fetch-queue bus: program load, redirect, optional loop control and the valid/ready instruction stream.
// Loop signals exist only when IFETCH_LOOP_EN is defined.
interface instruction_fetch_queue_if #(
    parameter int DW = 32,
    parameter int AW = 8,
    parameter int LW = 8
);
    logic [AW:0]   instruction_count;
    logic [DW-1:0] inst;
    logic          inst_valid;
    logic          inst_ready;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          prog_wen;
    logic [AW-1:0] prog_addr;
    logic [DW-1:0] prog_data;
    logic          done;
`ifdef IFETCH_LOOP_EN
    logic          loop_arm;
    logic [AW-1:0] loop_start;
    logic [AW-1:0] loop_end;
    logic [LW-1:0] loop_iters;
`endif

    modport master (
        output instruction_count, inst_ready, redirect_valid, redirect_addr,
               prog_wen, prog_addr, prog_data,
`ifdef IFETCH_LOOP_EN
        output loop_arm, loop_start, loop_end, loop_iters,
`endif
        input  inst, inst_valid, done
    );

    modport slave (
        input  instruction_count, inst_ready, redirect_valid, redirect_addr,
               prog_wen, prog_addr, prog_data,
`ifdef IFETCH_LOOP_EN
        input  loop_arm, loop_start, loop_end, loop_iters,
`endif
        output inst, inst_valid, done
    );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch front-end: sync-read program RAM feeding a valid/ready prefetch FIFO, with redirect,
// in-place program load and done flag. Define IFETCH_LOOP_EN to add the hardware loop (loop_* signals).
module instruction_fetch_queue #(
    parameter int DW     = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH),
    parameter int QDEPTH = 4,
    parameter int LW     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    instruction_fetch_queue_if.slave bus
);
    localparam int            QW       = $clog2(QDEPTH);
    localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [QW+1:0] QDEPTH_L = (QW+2)'(QDEPTH);

    if ((QDEPTH < 2) || ((QDEPTH & (QDEPTH - 1)) != 0) || (LW < 1)) begin : g_param_check
        $error("instruction_fetch_queue: QDEPTH must be a power of 2 >= 2 and LW >= 1");
    end

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] fifo_q [QDEPTH];
    logic [DW-1:0] rdata_q;
    logic [AW:0]   pc_q, pc_d;
    logic          inflight_q;
    logic [QW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [QW:0]   cnt_q, cnt_d, cnt_left_s;
    logic [DW-1:0] inst_q, inst_d;
    logic          inst_valid_q, inst_valid_d;
    logic          done_q, done_d;
    logic [AW:0]   limit_s;
    logic [QW+1:0] occ_s;
    logic          pop_s, push_s, issue_s;
`ifdef IFETCH_LOOP_EN
    logic [AW-1:0] loop_start_q, loop_start_d;
    logic [AW-1:0] loop_end_q, loop_end_d;
    logic [LW-1:0] loop_rem_q, loop_rem_d;
    logic          loop_back_s;
`endif

    // Fetch limit, handshake and issue qualifiers; occupancy counts the read still in flight
    always_comb begin
        limit_s = (bus.instruction_count > DEPTH_L) ? DEPTH_L : bus.instruction_count;
        occ_s   = {1'b0, cnt_q} + {{(QW+1){1'b0}}, inflight_q};
        pop_s   = inst_valid_q & bus.inst_ready;
        push_s  = inflight_q & ~bus.redirect_valid;
        issue_s = (pc_q < limit_s) & ~bus.prog_wen & ~bus.redirect_valid & (occ_s < QDEPTH_L);
    end

    // Next fetch PC; redirect beats loop-back beats linear increment
    always_comb begin
`ifdef IFETCH_LOOP_EN
        loop_back_s  = issue_s && (pc_q == {1'b0, loop_end_q}) && (loop_rem_q != '0);
        loop_start_d = bus.loop_arm ? bus.loop_start : loop_start_q;
        loop_end_d   = bus.loop_arm ? bus.loop_end   : loop_end_q;
        if (bus.loop_arm) begin
            loop_rem_d = bus.loop_iters;
        end else if (bus.redirect_valid) begin
            loop_rem_d = '0;
        end else if (loop_back_s) begin
            loop_rem_d = loop_rem_q - LW'(1);
        end else begin
            loop_rem_d = loop_rem_q;
        end
`endif
        if (bus.redirect_valid) begin
            pc_d = {1'b0, bus.redirect_addr};
`ifdef IFETCH_LOOP_EN
        end else if (loop_back_s) begin
            pc_d = {1'b0, loop_start_q};
`endif
        end else if (issue_s) begin
            pc_d = pc_q + (AW+1)'(1);
        end else begin
            pc_d = pc_q;
        end
    end

    // FIFO bookkeeping; the head is registered so inst holds its last value when the queue empties
    always_comb begin
        cnt_left_s = cnt_q - {{QW{1'b0}}, pop_s};
        if (bus.redirect_valid) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            cnt_d        = '0;
            inst_valid_d = 1'b0;
            inst_d       = inst_q;
        end else begin
            rd_ptr_d     = rd_ptr_q + QW'(pop_s);
            wr_ptr_d     = wr_ptr_q + QW'(push_s);
            cnt_d        = cnt_left_s + {{QW{1'b0}}, push_s};
            inst_valid_d = (cnt_d != '0);
            if (cnt_d == '0) begin
                inst_d = inst_q;
            end else if (cnt_left_s == '0) begin
                inst_d = rdata_q;
            end else begin
                inst_d = fifo_q[rd_ptr_d];
            end
        end
        done_d = (pc_d >= limit_s) && (cnt_d == '0) && !issue_s;
    end

    // Storage arrays: program RAM write port and FIFO entry write
    always_ff @(posedge clk) begin
        if (bus.prog_wen) begin
            mem_q[bus.prog_addr] <= bus.prog_data;
        end
        if (push_s) begin
            fifo_q[wr_ptr_q] <= rdata_q;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= '0;
            inflight_q   <= 1'b0;
            rdata_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            inflight_q   <= issue_s;
            if (issue_s) begin
                rdata_q <= mem_q[pc_q[AW-1:0]];
            end
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            done_q       <= done_d;
        end
    end

`ifdef IFETCH_LOOP_EN
    // Hardware loop registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loop_start_q <= '0;
            loop_end_q   <= '0;
            loop_rem_q   <= '0;
        end else begin
            loop_start_q <= loop_start_d;
            loop_end_q   <= loop_end_d;
            loop_rem_q   <= loop_rem_d;
        end
    end
`endif

    assign bus.inst       = inst_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed instruction sequences and timings.
module tb_instruction_fetch_queue;
    localparam int DW = 32, DEPTH = 256, AW = 8, QDEPTH = 4, LW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_queue_if #(.DW(DW), .AW(AW), .LW(LW)) bus ();
    instruction_fetch_queue #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .QDEPTH(QDEPTH), .LW(LW))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every issued fetch becomes an entry visible two cycles later
    typedef struct { logic [DW-1:0] data; int rdy; } ent_t;
    logic [DW-1:0] m_mem [DEPTH];
    ent_t          m_q [$];
    int            m_pc, m_cyc, m_rem, m_lstart, m_lend;
    logic          m_done;
    logic [DW-1:0] m_last;

    // Observed handshakes, recorded from the DUT for directed checks
    logic [DW-1:0] hs_log [$];
    int            hs_cyc [$];
    int            t_cyc, done_cyc;

    always @(posedge clk) begin
        int  lim;
        bit  vis, iss;
        if (rst) begin
            m_q.delete();
            m_pc = 0; m_cyc = 0; m_rem = 0; m_lstart = 0; m_lend = 0; m_done = 1'b0;
        end else begin
            lim = (int'(bus.instruction_count) > DEPTH) ? DEPTH : int'(bus.instruction_count);
            vis = (m_q.size() > 0) && (m_q[0].rdy <= m_cyc);
            iss = (m_pc < lim) && !bus.prog_wen && !bus.redirect_valid && (m_q.size() < QDEPTH);
            if (vis && bus.inst_ready) void'(m_q.pop_front());
            if (bus.redirect_valid) begin
                m_q.delete();
                m_pc  = int'(bus.redirect_addr);
                m_rem = 0;
            end else if (iss) begin
                m_q.push_back('{data: m_mem[m_pc], rdy: m_cyc + 2});
                if (m_pc == m_lend && m_rem > 0) begin
                    m_pc = m_lstart;
                    m_rem--;
                end else begin
                    m_pc++;
                end
            end
            if (bus.prog_wen) m_mem[bus.prog_addr] = bus.prog_data;
`ifdef IFETCH_LOOP_EN
            if (bus.loop_arm) begin
                m_lstart = int'(bus.loop_start);
                m_lend   = int'(bus.loop_end);
                m_rem    = int'(bus.loop_iters);
            end
`endif
            m_done = (m_pc >= lim) && (m_q.size() == 0);
            m_cyc++;
        end
    end

    // Per-cycle comparison, sampled mid-cycle
    always @(negedge clk) begin
        bit exp_valid;
        if (rst) begin
            check("rst_inst_valid", bus.inst_valid, 1'b0);
            check("rst_inst", bus.inst, 32'h0);
            check("rst_done", bus.done, 1'b0);
            t_cyc = 0; done_cyc = -1; m_last = '0;
        end else begin
            exp_valid = (m_q.size() > 0) && (m_q[0].rdy <= m_cyc);
            if (exp_valid) m_last = m_q[0].data;
            check("inst_valid", bus.inst_valid, exp_valid);
            check("inst", bus.inst, m_last);
            check("done", bus.done, m_done);
            if (bus.inst_valid && bus.inst_ready) begin
                hs_log.push_back(bus.inst);
                hs_cyc.push_back(t_cyc);
            end
            if (bus.done && done_cyc < 0) done_cyc = t_cyc;
            t_cyc++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic redirect(input int addr);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = AW'(addr);
        step(1);
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        int base, rcyc;
        bus.instruction_count = '0;
        bus.inst_ready        = 1'b0;
        bus.redirect_valid    = 1'b0;
        bus.redirect_addr     = '0;
        bus.prog_wen          = 1'b0;
        bus.prog_addr         = '0;
        bus.prog_data         = '0;
`ifdef IFETCH_LOOP_EN
        bus.loop_arm   = 1'b0;
        bus.loop_start = '0;
        bus.loop_end   = '0;
        bus.loop_iters = '0;
`endif
        step(2);
        rst = 1'b0;

        // Load words 0..15 with limit 0: nothing fetched, done rises
        for (int i = 0; i < 16; i++) begin
            bus.prog_wen  = 1'b1;
            bus.prog_addr = AW'(i);
            bus.prog_data = 32'h100 + i;
            step(1);
        end
        bus.prog_wen = 1'b0;
        step(2);
        check("done_limit0", bus.done, 1'b1);

        // Linear fetch of 10 words, consumer always ready
        rst = 1'b1;
        bus.instruction_count = 9'd10;
        bus.inst_ready        = 1'b1;
        step(1);
        rst  = 1'b0;
        base = hs_log.size();
        step(16);
        check("lin_count", hs_log.size() - base, 10);
        for (int i = 0; i < 10; i++) check("lin_data", hs_log[base+i], 32'h100 + i);
        check("lin_first_cyc", hs_cyc[base], 2);
        check("lin_last_cyc", hs_cyc[base+9], 11);
        check("lin_done_cyc", done_cyc, 12);

        // Consumer stalls: queue fills to QDEPTH, then drains without loss or duplication
        bus.inst_ready = 1'b0;
        redirect(0);
        step(20);
        check("stall_valid", bus.inst_valid, 1'b1);
        check("stall_inst", bus.inst, 32'h100);
        check("stall_done", bus.done, 1'b0);
        base = hs_log.size();
        bus.inst_ready = 1'b1;
        step(14);
        check("stall_count", hs_log.size() - base, 10);
        for (int i = 0; i < 10; i++) check("stall_data", hs_log[base+i], 32'h100 + i);

        // Redirect to 7 with 3 entries queued; handshake in the redirect cycle still completes
        bus.inst_ready = 1'b0;
        redirect(0);
        step(4);
        base = hs_log.size();
        rcyc = t_cyc;
        bus.inst_ready = 1'b1;
        redirect(7);
        step(8);
        check("redir_count", hs_log.size() - base, 4);
        check("redir_hs_in_cycle", hs_log[base], 32'h100);
        check("redir_target", hs_log[base+1], 32'h107);
        check("redir_target_cyc", hs_cyc[base+1], rcyc + 3);
        check("redir_last", hs_log[base+3], 32'h109);

        // Redirect beyond the limit with a full queue: flushed, done rises
        bus.inst_ready = 1'b0;
        redirect(0);
        step(4);
        check("oob_done_before", bus.done, 1'b0);
        redirect(12);
        check("oob_done", bus.done, 1'b1);
        check("oob_valid", bus.inst_valid, 1'b0);

        // Program writes every other cycle: half throughput, order preserved
        bus.inst_ready = 1'b1;
        redirect(0);
        base = hs_log.size();
        for (int k = 0; k < 24; k++) begin
            bus.prog_wen  = (k % 2 == 0);
            bus.prog_addr = AW'(100 + k);
            bus.prog_data = 32'hA000 + k;
            step(1);
        end
        bus.prog_wen = 1'b0;
        step(4);
        check("wen_count", hs_log.size() - base, 10);
        for (int i = 0; i < 10; i++) check("wen_data", hs_log[base+i], 32'h100 + i);
        check("wen_span", hs_cyc[base+9] - hs_cyc[base], 18);

        // Reset mid-stream with 2 entries queued
        bus.inst_ready = 1'b0;
        redirect(0);
        step(3);
        check("pre_rst_valid", bus.inst_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", bus.inst_valid, 1'b0);
        step(1);
        rst  = 1'b0;
        base = hs_log.size();
        bus.inst_ready = 1'b1;
        step(6);
        check("restart_data", hs_log[base], 32'h100);
        check("restart_cyc", hs_cyc[base], 2);
        check("restart_next", hs_log[base+1], 32'h101);

`ifdef IFETCH_LOOP_EN
        // Loop body 2..4 executed three times in total
        begin
            int exp_addr [12] = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 4, 5};
            rst = 1'b1;
            bus.instruction_count = 9'd0;
            step(1);
            rst = 1'b0;
            bus.loop_arm   = 1'b1;
            bus.loop_start = 8'd2;
            bus.loop_end   = 8'd4;
            bus.loop_iters = 8'd2;
            step(1);
            bus.loop_arm = 1'b0;
            bus.instruction_count = 9'd6;
            bus.inst_ready = 1'b1;
            base = hs_log.size();
            step(20);
            check("loop_count", hs_log.size() - base, 12);
            for (int i = 0; i < 12; i++) check("loop_data", hs_log[base+i], 32'h100 + exp_addr[i]);
            check("loop_done", bus.done, 1'b1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
